// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and helpers for the 4x4 keypad entry path.
// Holds scan FSM state encodings, key code constants, operand target
// encodings and small decode functions used by keypad_scan and keypad_entry.
package keypad_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned VALUE_W = 16;
    localparam int unsigned NDIG_W  = 3;
    localparam int unsigned TGT_W   = 2;

    // Scan FSM states
    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_ACT      = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Non-digit key codes (code = 4*row + col)
    localparam logic [KEY_W-1:0] KEY_A    = 4'd3;
    localparam logic [KEY_W-1:0] KEY_B    = 4'd7;
    localparam logic [KEY_W-1:0] KEY_C    = 4'd11;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'd12;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'd14;
    localparam logic [KEY_W-1:0] KEY_D    = 4'd15;

    // Operand target, same encoding as display output enables
    localparam logic [TGT_W-1:0] TGT_REG1 = 2'b01;
    localparam logic [TGT_W-1:0] TGT_REG2 = 2'b10;

    // True for the ten numeric keys
    function automatic logic key_is_digit(input logic [KEY_W-1:0] code);
        logic is_d;
        case (code)
            KEY_A, KEY_B, KEY_C, KEY_STAR, KEY_HASH, KEY_D: is_d = 1'b0;
            default:                                        is_d = 1'b1;
        endcase
        return is_d;
    endfunction

    // BCD digit printed on a numeric key; non-digit codes return 0
    function automatic logic [3:0] key_digit(input logic [KEY_W-1:0] code);
        logic [3:0] d;
        case (code)
            4'd0:    d = 4'd1;
            4'd1:    d = 4'd2;
            4'd2:    d = 4'd3;
            4'd4:    d = 4'd4;
            4'd5:    d = 4'd5;
            4'd6:    d = 4'd6;
            4'd8:    d = 4'd7;
            4'd9:    d = 4'd8;
            4'd10:   d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // Lowest set column wins when several keys in one row are down
    function automatic logic [1:0] lowest_col(input logic [3:0] c);
        logic [1:0] idx;
        if (c[0])      idx = 2'd0;
        else if (c[1]) idx = 2'd1;
        else if (c[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    // Index of the driven row from the one-hot row drive
    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: drives keypad rows one-hot, synchronizes and debounces the
// column sense and reports each accepted key exactly once.
// Ports:
//   clk, rst        clock, async active-high reset
//   cols            raw column sense (asynchronous)
//   rows            registered one-hot row drive
//   key_valid       registered one-cycle pulse per accepted key
//   key_code        registered code of accepted key (4*row+col)
//   act_c           combinational: FSM is in ACT this cycle
//   act_code_c      combinational: code of the key being acted on
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cols,
    output logic [3:0]       rows,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             act_c,
    output logic [KEY_W-1:0] act_code_c
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       cols_s1_q, cols_s2_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       rows_q, rows_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [1:0]       col_q, col_d;
    logic             key_valid_q, key_valid_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic [3:0]       rows_next;

    assign rows_next  = {rows_q[2:0], rows_q[3]};
    assign act_c      = (state_q == ST_ACT);
    assign act_code_c = {row_index(rows_q), col_q};

    // Two-flop column synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_s1_q <= '0;
            cols_s2_q <= '0;
        end else begin
            cols_s1_q <= cols;
            cols_s2_q <= cols_s1_q;
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            rows_q      <= 4'b0001;
            div_q       <= '0;
            deb_q       <= '0;
            col_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            div_q       <= div_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    // Scan FSM next state
    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        div_d       = div_q;
        deb_d       = deb_q;
        col_d       = col_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        case (state_q)
            ST_SCAN: begin
                // Sample only in the last dwell cycle so the synchronized
                // columns reflect the row currently driven
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (cols_s2_q != 4'b0) begin
                        col_d   = lowest_col(cols_s2_q);
                        deb_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        rows_d = rows_next;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (cols_s2_q[col_q]) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        state_d = ST_ACT;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    deb_d   = '0;
                    div_d   = '0;
                    rows_d  = rows_next;
                    state_d = ST_SCAN;
                end
            end
            ST_ACT: begin
                key_valid_d = 1'b1;
                key_code_d  = act_code_c;
                deb_d       = '0;
                state_d     = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Any column activity restarts the release window
                if (cols_s2_q == 4'b0) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        div_d   = '0;
                        rows_d  = rows_next;
                        state_d = ST_SCAN;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    assign rows      = rows_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad front end that accumulates up to four BCD digits,
// selects the destination operand register and pulses enter on '#'.
// Ports:
//   clk, rst     clock, async active-high reset
//   cols         raw keypad column sense
//   rows         one-hot row drive
//   value        accumulated BCD digits, [15:12] most significant
//   ndigits      number of digits held (0..4)
//   target       01 = reg1, 10 = reg2
//   enter        one-cycle commit pulse
//   key_valid    one-cycle pulse per accepted key
//   key_code     accepted key code, valid with key_valid
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         cols,
    output logic [3:0]         rows,
    output logic [VALUE_W-1:0] value,
    output logic [NDIG_W-1:0]  ndigits,
    output logic [TGT_W-1:0]   target,
    output logic               enter,
    output logic               key_valid,
    output logic [KEY_W-1:0]   key_code
);

    logic               act_c;
    logic [KEY_W-1:0]   act_code_c;
    logic [3:0]         digit_c;

    logic [VALUE_W-1:0] value_q, value_d;
    logic [NDIG_W-1:0]  ndig_q, ndig_d;
    logic [TGT_W-1:0]   target_q, target_d;
    logic               fresh_q, fresh_d;
    logic               enter_q, enter_d;

    keypad_scan #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .cols       (cols),
        .rows       (rows),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .act_c      (act_c),
        .act_code_c (act_code_c)
    );

    assign digit_c = key_digit(act_code_c);

    // Accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q  <= '0;
            ndig_q   <= '0;
            target_q <= TGT_REG1;
            fresh_q  <= 1'b0;
            enter_q  <= 1'b0;
        end else begin
            value_q  <= value_d;
            ndig_q   <= ndig_d;
            target_q <= target_d;
            fresh_q  <= fresh_d;
            enter_q  <= enter_d;
        end
    end

    // Key actions; fresh makes the first digit after a commit start a new value
    always_comb begin
        value_d  = value_q;
        ndig_d   = ndig_q;
        target_d = target_q;
        fresh_d  = fresh_q;
        enter_d  = 1'b0;
        if (act_c) begin
            if (key_is_digit(act_code_c)) begin
                if (fresh_q) begin
                    value_d = {12'h000, digit_c};
                    ndig_d  = NDIG_W'(1);
                    fresh_d = 1'b0;
                end else if (ndig_q < NDIG_W'(4)) begin
                    value_d = {value_q[11:0], digit_c};
                    ndig_d  = ndig_q + NDIG_W'(1);
                end
            end else begin
                case (act_code_c)
                    KEY_A: target_d = TGT_REG1;
                    KEY_B: target_d = TGT_REG2;
                    KEY_C: begin
                        value_d = '0;
                        ndig_d  = '0;
                        fresh_d = 1'b0;
                    end
                    KEY_HASH: begin
                        enter_d = 1'b1;
                        fresh_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign value   = value_q;
    assign ndigits = ndig_q;
    assign target  = target_q;
    assign enter   = enter_q;

endmodule
